// File: rtl/vic_core_pkg.sv
// Shared constants and types for the vectored interrupt controller.
// Holds the register-map address of the global control word and the cfg bit positions.
package vic_core_pkg;

    localparam int         NUM_LINES   = 31;
    localparam logic [4:0] ADDR_GLOBAL = 5'd31;

    localparam int CFG_EN   = 3;
    localparam int CFG_RISE = 2;
    localparam int CFG_FALL = 1;
    localparam int CFG_POL  = 0;

    localparam int GLB_GIE  = 0;

    typedef enum logic {
        ST_IDLE,
        ST_BUSY
    } vic_state_e;

endpackage

// File: rtl/vic_prio_enc.sv
// Fixed-priority encoder: reports the lowest-index asserted request line.
module vic_prio_enc
    import vic_core_pkg::*;
(
    input  logic [NUM_LINES-1:0] req,
    output logic [4:0]           id,
    output logic                 valid
);

    // Scanning from the top down lets the lowest asserted index overwrite the others.
    always_comb begin
        id    = '0;
        valid = 1'b0;
        for (int k = NUM_LINES - 1; k >= 0; k--) begin
            if (req[k]) begin
                id    = 5'(k);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/vic_core.sv
// Single-level vectored interrupt controller beside the fetch stage:
// per-line edge/level requests, lowest-index priority, PC/CC save and restore on RETI.
module vic_core
    import vic_core_pkg::*;
#(
    parameter logic [31:0] VECTOR_BASE   = 32'h0000_0010,
    parameter int unsigned VECTOR_STRIDE = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [31:0]          i_PC,
    input  logic [3:0]           i_VIC_data,
    input  logic [4:0]           i_VIC_regaddr,
    input  logic                 i_VIC_we,
    input  logic [NUM_LINES-1:0] i_ext,
    input  logic                 i_reti,
    input  logic [3:0]           i_CCodes,
    output logic [3:0]           o_CCodes,
    output logic [3:0]           o_VIC_data,
    output logic [31:0]          o_VIC_iaddr,
    output logic                 o_VIC_ctrl
);

    logic [3:0]           cfg [NUM_LINES];
    logic                 gie;
    logic [NUM_LINES-1:0] pend;
    logic [NUM_LINES-1:0] ext_q;
    logic [NUM_LINES-1:0] rise;
    logic [NUM_LINES-1:0] fall;
    logic [NUM_LINES-1:0] edge_hit;
    logic [NUM_LINES-1:0] req;
    logic [NUM_LINES-1:0] pend_clr;

    vic_state_e           state;
    logic [31:0]          saved_pc;
    logic [3:0]           saved_cc;
    logic                 restore;
    logic                 ctrl_q;
    logic [31:0]          iaddr_q;

    logic [4:0]           win_id;
    logic                 win_valid;
    logic                 do_accept;
    logic [31:0]          vector;

    assign rise = i_ext & ~ext_q;
    assign fall = ~i_ext & ext_q;

    // Edge-mode lines request from their latched pending bit; level-mode lines straight from the pin.
    always_comb begin
        edge_hit = '0;
        req      = '0;
        for (int k = 0; k < NUM_LINES; k++) begin
            edge_hit[k] = cfg[k][CFG_EN] &
                          ((cfg[k][CFG_RISE] & rise[k]) | (cfg[k][CFG_FALL] & fall[k]));
            if (cfg[k][CFG_RISE] | cfg[k][CFG_FALL])
                req[k] = cfg[k][CFG_EN] & pend[k];
            else
                req[k] = cfg[k][CFG_EN] & (i_ext[k] == cfg[k][CFG_POL]);
        end
    end

    vic_prio_enc u_prio (
        .req   (req),
        .id    (win_id),
        .valid (win_valid)
    );

    // The ctrl_q term keeps a fresh accept from landing right behind a return pulse.
    assign do_accept = gie & (state == ST_IDLE) & ~ctrl_q & win_valid;
    assign vector    = VECTOR_BASE + 32'(win_id) * 32'(VECTOR_STRIDE);

    always_comb begin
        pend_clr = '0;
        for (int k = 0; k < NUM_LINES; k++) begin
            pend_clr[k] = (i_VIC_we && i_VIC_regaddr == 5'(k)) ||
                          (do_accept && win_id == 5'(k));
        end
    end

    // Configuration registers, global enable, pending bits and the previous input sample.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < NUM_LINES; k++) cfg[k] <= '0;
            gie   <= 1'b0;
            pend  <= '0;
            ext_q <= '0;
        end else begin
            ext_q <= i_ext;
            pend  <= (pend | edge_hit) & ~pend_clr;
            if (i_VIC_we) begin
                if (i_VIC_regaddr == ADDR_GLOBAL)
                    gie <= i_VIC_data[GLB_GIE];
                else
                    cfg[i_VIC_regaddr] <= i_VIC_data;
            end
        end
    end

    // Service FSM: IDLE accepts the winning request, BUSY waits for RETI to restore context.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_IDLE;
            saved_pc <= '0;
            saved_cc <= '0;
            restore  <= 1'b0;
            ctrl_q   <= 1'b0;
            iaddr_q  <= '0;
        end else begin
            ctrl_q  <= 1'b0;
            restore <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (do_accept) begin
                        state    <= ST_BUSY;
                        ctrl_q   <= 1'b1;
                        iaddr_q  <= vector;
                        saved_pc <= i_PC;
                        saved_cc <= i_CCodes;
                    end
                end
                ST_BUSY: begin
                    if (i_reti) begin
                        state   <= ST_IDLE;
                        ctrl_q  <= 1'b1;
                        iaddr_q <= saved_pc;
                        restore <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        o_VIC_data = '0;
        if (i_VIC_regaddr == ADDR_GLOBAL)
            o_VIC_data = {2'b00, state == ST_BUSY, gie};
        else
            o_VIC_data = cfg[i_VIC_regaddr];
    end

    assign o_CCodes    = restore ? saved_cc : i_CCodes;
    assign o_VIC_ctrl  = ctrl_q;
    assign o_VIC_iaddr = iaddr_q;

endmodule

// File: tb/tb_vic_core.sv
// Scoreboard bench for vic_core: a cycle-level reference model predicts every redirect pulse
// and register read; a monitor compares whatever the controller presents.
module tb_vic_core;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] iPc = '0;
    logic [3:0]  vicData = '0;
    logic [4:0]  regAddr = '0;
    logic        we = 1'b0;
    logic [30:0] ext = '0;
    logic        reti = 1'b0;
    logic [3:0]  ccIn = '0;
    logic [3:0]  ccOut;
    logic [3:0]  dataOut;
    logic [31:0] iaddr;
    logic        ctrl;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  cc;
        bit          ret;
    } exp_t;
    exp_t sb[$];

    // Reference model state
    logic [3:0]  mCfg [31];
    bit   [30:0] mPend = '0;
    bit   [30:0] mExtPrev = '0;
    bit          mGie = 1'b0;
    bit          mBusy = 1'b0;
    bit          mLastPulse = 1'b0;
    logic [31:0] mSavedPc = '0;
    logic [3:0]  mSavedCc = '0;

    vic_core dut (
        .clk          (clk),
        .rst          (rst),
        .i_PC         (iPc),
        .i_VIC_data   (vicData),
        .i_VIC_regaddr(regAddr),
        .i_VIC_we     (we),
        .i_ext        (ext),
        .i_reti       (reti),
        .i_CCodes     (ccIn),
        .o_CCodes     (ccOut),
        .o_VIC_data   (dataOut),
        .o_VIC_iaddr  (iaddr),
        .o_VIC_ctrl   (ctrl)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input int cycles);
        repeat (cycles) @(negedge clk);
    endtask

    task automatic writeReg(input logic [4:0] a, input logic [3:0] d);
        @(negedge clk);
        regAddr = a;
        vicData = d;
        we = 1'b1;
        @(negedge clk);
        we = 1'b0;
    endtask

    task automatic pulseReti();
        @(negedge clk);
        reti = 1'b1;
        @(negedge clk);
        reti = 1'b0;
    endtask

    task automatic readCheck(input string name, input logic [4:0] a, input logic [3:0] expected);
        @(negedge clk);
        regAddr = a;
        #2;
        checkOutput(name, 32'(dataOut), 32'(expected));
    endtask

    // Reference model: one step per rising edge, written from the register-map and service rules.
    initial begin
        bit          found;
        int          id;
        bit          en;
        bit          edgeMode;
        bit          nextPulse;
        exp_t        e;
        for (int k = 0; k < 31; k++) mCfg[k] = '0;
        forever begin
            @(posedge clk);
            if (!rst) begin
                for (int k = 0; k < 31; k++) mCfg[k] = '0;
                mPend = '0; mExtPrev = '0; mGie = 0; mBusy = 0; mLastPulse = 0;
                mSavedPc = '0; mSavedCc = '0;
            end else begin
                found = 0;
                id = 0;
                for (int k = 0; k < 31; k++) begin
                    en = mCfg[k][3];
                    edgeMode = mCfg[k][2] || mCfg[k][1];
                    if (!found && en && (edgeMode ? mPend[k] : (ext[k] == mCfg[k][0]))) begin
                        found = 1;
                        id = k;
                    end
                end
                for (int k = 0; k < 31; k++) begin
                    if (mCfg[k][3] && ((mCfg[k][2] && ext[k] && !mExtPrev[k]) ||
                                       (mCfg[k][1] && !ext[k] && mExtPrev[k])))
                        mPend[k] = 1'b1;
                end
                nextPulse = 0;
                if (mBusy && reti) begin
                    e.addr = mSavedPc; e.cc = mSavedCc; e.ret = 1;
                    sb.push_back(e);
                    mBusy = 0;
                    nextPulse = 1;
                end else if (mGie && !mBusy && !mLastPulse && found) begin
                    e.addr = 32'h10 + 32'(id) * 32'd4; e.cc = '0; e.ret = 0;
                    sb.push_back(e);
                    mSavedPc = iPc;
                    mSavedCc = ccIn;
                    mBusy = 1;
                    mPend[id] = 1'b0;
                    nextPulse = 1;
                end
                if (we) begin
                    if (regAddr == 5'd31) mGie = vicData[0];
                    else begin
                        mCfg[regAddr] = vicData;
                        mPend[regAddr] = 1'b0;
                    end
                end
                mExtPrev = ext;
                mLastPulse = nextPulse;
            end
        end
    end

    // Monitor: pops one expectation for every redirect pulse and checks register reads each cycle.
    initial begin
        exp_t        e;
        logic [3:0]  expRead;
        forever begin
            @(negedge clk);
            #1;
            if (!rst) begin
                sb.delete();
            end else begin
                expRead = (regAddr == 5'd31) ? {2'b00, mBusy, mGie} : mCfg[regAddr];
                checkOutput("reg_read", 32'(dataOut), 32'(expRead));
                checkOutput("pulse", 32'(ctrl), 32'(sb.size() != 0));
                if (ctrl && sb.size() != 0) begin
                    e = sb.pop_front();
                    checkOutput(e.ret ? "ret_addr" : "vec_addr", iaddr, e.addr);
                    checkOutput("ccodes", 32'(ccOut), 32'(e.ret ? e.cc : ccIn));
                end else if (sb.size() != 0) begin
                    void'(sb.pop_front());
                end
            end
        end
    end

    initial begin
        logic [3:0] cfgChoices [7];
        cfgChoices[0] = 4'hC; cfgChoices[1] = 4'hA; cfgChoices[2] = 4'hE;
        cfgChoices[3] = 4'h9; cfgChoices[4] = 4'h8; cfgChoices[5] = 4'h4; cfgChoices[6] = 4'h0;

        // Reset state: every register reads zero, outputs idle
        applyStimulus(3);
        for (int a = 0; a < 32; a++) begin
            regAddr = 5'(a);
            #1;
            checkOutput("reset_read", 32'(dataOut), 32'd0);
        end
        checkOutput("reset_ctrl", 32'(ctrl), 32'd0);
        checkOutput("reset_iaddr", iaddr, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        writeReg(5'd1, 4'hC);
        readCheck("cfg1_readback", 5'd1, 4'hC);

        // Rising edge on line 1 with GIE set
        iPc = 32'hFFFF_FFFF;
        ccIn = 4'hF;
        writeReg(5'd31, 4'h1);
        @(negedge clk); ext[1] = 1'b1;
        @(negedge clk); ext[1] = 1'b0;
        applyStimulus(4);
        readCheck("busy_after_accept", 5'd31, 4'h3);

        // Return restores PC and condition codes
        @(negedge clk);
        ccIn = 4'h0;
        iPc = 32'h0;
        pulseReti();
        applyStimulus(3);
        readCheck("busy_after_reti", 5'd31, 4'h1);

        // Priority: level-high line 2 beats falling-edge line 8
        writeReg(5'd8, 4'hA);
        writeReg(5'd2, 4'h9);
        @(negedge clk); ext[8] = 1'b1; ext[2] = 1'b1;
        @(negedge clk); ext[8] = 1'b0;
        applyStimulus(3);
        ext[2] = 1'b0;
        pulseReti();
        applyStimulus(4);
        pulseReti();
        applyStimulus(3);

        // Level-low line 3 is re-serviced after every return until the pin goes high
        writeReg(5'd3, 4'h8);
        applyStimulus(3);
        repeat (3) begin
            pulseReti();
            applyStimulus(3);
        end
        @(negedge clk); ext[3] = 1'b1;
        pulseReti();
        applyStimulus(5);
        writeReg(5'd3, 4'h0);

        // GIE gating, then reset in mid-service
        writeReg(5'd31, 4'h0);
        writeReg(5'd5, 4'hC);
        @(negedge clk); ext[5] = 1'b1;
        @(negedge clk); ext[5] = 1'b0;
        applyStimulus(5);
        writeReg(5'd31, 4'h1);
        applyStimulus(3);
        readCheck("busy_gie_serviced", 5'd31, 4'h3);
        @(negedge clk);
        rst = 1'b0;
        ccIn = 4'h0;
        regAddr = 5'd31;
        #2;
        checkOutput("midreset_ctrl", 32'(ctrl), 32'd0);
        checkOutput("midreset_iaddr", iaddr, 32'd0);
        checkOutput("midreset_cc", 32'(ccOut), 32'd0);
        checkOutput("midreset_global", 32'(dataOut), 32'd0);
        @(negedge clk);
        ext = '0;
        rst = 1'b1;

        // Randomized traffic against the reference model
        for (int k = 0; k < 31; k++) writeReg(5'(k), cfgChoices[$urandom_range(0, 6)]);
        writeReg(5'd31, 4'h1);
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            ext ^= 31'($urandom & $urandom & $urandom & $urandom);
            iPc = $urandom;
            ccIn = 4'($urandom);
            reti = ($urandom_range(0, 4) == 0);
            we = ($urandom_range(0, 39) == 0);
            regAddr = 5'($urandom);
            vicData = we && regAddr == 5'd31 ? 4'($urandom_range(0, 7) != 0) : 4'($urandom);
        end
        @(negedge clk);
        reti = 1'b0;
        we = 1'b0;
        applyStimulus(5);
        checkOutput("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
